// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined ARM CPU.
// Contents:
//   DATA_WIDTH            - datapath / address width
//   OP_*                  - 5-bit opcode constants
//   mem_state_e           - encoding of the memory-access FSM
//   is_word_aligned()     - true when a byte address is on a 32-bit word boundary
package cpu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_LDR = 5'b10010;
    localparam logic [4:0] OP_STR = 5'b10011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Sequencer for one data-memory access in the MEM stage.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   enable            - pipeline advance; 0 freezes state and counter
//   mem_access        - current EX/MEM instruction is a load or store
//   aligned           - its effective address is word aligned
//   dmem_ready        - memory completes the access this cycle
//   dmem_req          - request to data memory (combinational)
//   stall_out         - hold upstream pipeline (combinational)
//   complete          - access finishes on the coming edge
//   abort             - access is dropped (misaligned or timed out) on the coming edge
//   bubble            - MEM/WB must load a bubble on the coming edge
module mem_access_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic mem_access,
    input  logic aligned,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic stall_out,
    output logic complete,
    output logic abort,
    output logic bubble
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e       state_r;
    mem_state_e       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             req_s;
    logic             stall_s;

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else if (enable) begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end
    end

    // Next-state, handshake and strobe decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;
        bubble       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Only issue when the pipeline advances, so a frozen pipeline
                // never lets memory perform an access we would then ignore.
                if (mem_access && enable) begin
                    if (aligned) begin
                        req_s = 1'b1;
                        if (dmem_ready) begin
                            complete = 1'b1;
                        end else begin
                            stall_s      = 1'b1;
                            bubble       = 1'b1;
                            state_next_s = ST_WAIT;
                            cnt_next_s   = CNT_W'(1);
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_WAIT: begin
                req_s = 1'b1;
                if (enable) begin
                    // Ready wins over timeout when both land in the same cycle.
                    if (dmem_ready) begin
                        complete     = 1'b1;
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                    end else if (cnt_r == CNT_LIMIT) begin
                        abort        = 1'b1;
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                    end else begin
                        stall_s    = 1'b1;
                        bubble     = 1'b1;
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Keep the memory port and upstream quiet while reset is applied
    always_comb begin
        if (reset) begin
            dmem_req  = 1'b0;
            stall_out = 1'b0;
        end else begin
            dmem_req  = req_s;
            stall_out = stall_s;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage ARM pipeline: drives the data-memory port for
// LDR/STR, stalls upstream while an access is outstanding, and registers the
// instruction into the MEM/WB pipeline register.
// Ports:
//   clk, reset, enable            - clock, sync active-high reset, pipeline advance
//   *_in_exmem                    - EX/MEM pipeline register contents
//   dmem_req/we/addr/wdata        - data-memory request (combinational)
//   dmem_rdata, dmem_ready        - data-memory response
//   stall_out                     - hold IF/ID/EX and EX/MEM
//   mem_fault                     - one-cycle pulse on misaligned/timeout abort
//   *_out_memwb                   - MEM/WB pipeline register outputs
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pc_in_exmem,
    input  logic [DATA_WIDTH-1:0] alu_result_in_exmem,
    input  logic [DATA_WIDTH-1:0] store_data_in_exmem,
    input  logic [3:0]            Rd_in_exmem,
    input  logic [4:0]            opcode_in_exmem,
    input  logic                  reg_write_en_in_exmem,
    input  logic                  mem_to_reg_in_exmem,
    input  logic                  mem_read_in_exmem,
    input  logic                  mem_write_in_exmem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  stall_out,
    output logic                  mem_fault,
    output logic [DATA_WIDTH-1:0] pc_out_memwb,
    output logic [DATA_WIDTH-1:0] alu_result_out_memwb,
    output logic [DATA_WIDTH-1:0] mem_read_data_out_memwb,
    output logic [3:0]            Rd_out_memwb,
    output logic [4:0]            opcode_out_memwb,
    output logic                  reg_write_en_out_memwb,
    output logic                  mem_to_reg_out_memwb
);

    logic                  mem_access_s;
    logic                  aligned_s;
    logic                  complete_s;
    logic                  abort_s;
    logic                  bubble_s;

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] alu_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [3:0]            rd_r;
    logic [4:0]            opcode_r;
    logic                  reg_write_r;
    logic                  mem_to_reg_r;
    logic                  fault_r;

    assign mem_access_s = mem_read_in_exmem | mem_write_in_exmem;
    assign aligned_s    = is_word_aligned(alu_result_in_exmem[1:0]);

    assign dmem_addr  = alu_result_in_exmem;
    assign dmem_wdata = store_data_in_exmem;
    assign dmem_we    = mem_write_in_exmem;

    mem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mem_access (mem_access_s),
        .aligned    (aligned_s),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .stall_out  (stall_out),
        .complete   (complete_s),
        .abort      (abort_s),
        .bubble     (bubble_s)
    );

    // MEM/WB pipeline register and fault pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= '0;
            alu_r        <= '0;
            rdata_r      <= '0;
            rd_r         <= 4'h0;
            opcode_r     <= 5'b00000;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            fault_r      <= 1'b0;
        end else if (enable) begin
            fault_r <= abort_s;
            if (bubble_s) begin
                pc_r         <= '0;
                alu_r        <= '0;
                rdata_r      <= '0;
                rd_r         <= 4'h0;
                opcode_r     <= 5'b00000;
                reg_write_r  <= 1'b0;
                mem_to_reg_r <= 1'b0;
            end else begin
                pc_r         <= pc_in_exmem;
                alu_r        <= alu_result_in_exmem;
                rd_r         <= Rd_in_exmem;
                opcode_r     <= opcode_in_exmem;
                mem_to_reg_r <= mem_to_reg_in_exmem;
                // An aborted access must never reach the register file.
                reg_write_r  <= reg_write_en_in_exmem & ~abort_s;
                rdata_r      <= (complete_s && mem_read_in_exmem) ? dmem_rdata : '0;
            end
        end else begin
            // Frozen pipeline: the register holds, the fault stays a single pulse.
            fault_r <= 1'b0;
        end
    end

    assign pc_out_memwb            = pc_r;
    assign alu_result_out_memwb    = alu_r;
    assign mem_read_data_out_memwb = rdata_r;
    assign Rd_out_memwb            = rd_r;
    assign opcode_out_memwb        = opcode_r;
    assign reg_write_en_out_memwb  = reg_write_r;
    assign mem_to_reg_out_memwb    = mem_to_reg_r;
    assign mem_fault               = fault_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, scoreboard-based bench for mem_stage.
module tb_mem_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [31:0] pc_in, alu_in, sd_in;
    logic [3:0]  rd_in;
    logic [4:0]  op_in;
    logic        rw_in, m2r_in, mr_in, mw_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_out, mem_fault;
    logic [31:0] pc_out, alu_out, rdata_out;
    logic [3:0]  rd_out;
    logic [4:0]  op_out;
    logic        rw_out, m2r_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [3:0]  rd;
        logic [4:0]  op;
        logic        rw;
        logic        m2r;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    mem_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .pc_in_exmem             (pc_in),
        .alu_result_in_exmem     (alu_in),
        .store_data_in_exmem     (sd_in),
        .Rd_in_exmem             (rd_in),
        .opcode_in_exmem         (op_in),
        .reg_write_en_in_exmem   (rw_in),
        .mem_to_reg_in_exmem     (m2r_in),
        .mem_read_in_exmem       (mr_in),
        .mem_write_in_exmem      (mw_in),
        .dmem_req                (dmem_req),
        .dmem_we                 (dmem_we),
        .dmem_addr               (dmem_addr),
        .dmem_wdata              (dmem_wdata),
        .dmem_rdata              (dmem_rdata),
        .dmem_ready              (dmem_ready),
        .stall_out               (stall_out),
        .mem_fault               (mem_fault),
        .pc_out_memwb            (pc_out),
        .alu_result_out_memwb    (alu_out),
        .mem_read_data_out_memwb (rdata_out),
        .Rd_out_memwb            (rd_out),
        .opcode_out_memwb        (op_out),
        .reg_write_en_out_memwb  (rw_out),
        .mem_to_reg_out_memwb    (m2r_out)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [3:0] rd, input logic [4:0] op, input logic rw,
                         input logic m2r, input logic mr, input logic mw);
        pc_in = pc; alu_in = alu; sd_in = sd; rd_in = rd; op_in = op;
        rw_in = rw; m2r_in = m2r; mr_in = mr; mw_in = mw;
    endtask

    // Pop the oldest expected retirement and compare it with MEM/WB.
    task automatic check_retire();
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: DUT retired with nothing expected");
        end else begin
            e = sb_q.pop_front();
            check("pc_out", pc_out, e.pc);
            check("alu_out", alu_out, e.alu);
            check("rdata_out", rdata_out, e.rdata);
            check("rd_out", {28'd0, rd_out}, {28'd0, e.rd});
            check("op_out", {27'd0, op_out}, {27'd0, e.op});
            check("rw_out", {31'd0, rw_out}, {31'd0, e.rw});
            check("m2r_out", {31'd0, m2r_out}, {31'd0, e.m2r});
            check("mem_fault", {31'd0, mem_fault}, {31'd0, e.fault});
        end
    endtask

    // Issue one instruction; ready_at = cycle index of dmem_ready (-1 = never).
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                             input logic [3:0] rd, input logic [4:0] op, input logic rw,
                             input logic m2r, input logic mr, input logic mw,
                             input int ready_at, input logic [31:0] rdata);
        exp_t e;
        logic mem, al, flt;
        int   end_k;
        bit   retired;
        mem = mr | mw;
        al  = (alu[1:0] == 2'b00);
        if (!mem) begin
            end_k = 0; flt = 1'b0;
        end else if (!al) begin
            end_k = 0; flt = 1'b1;
        end else if (ready_at >= 0 && ready_at <= TMO) begin
            end_k = ready_at; flt = 1'b0;
        end else begin
            end_k = TMO; flt = 1'b1;
        end
        e.pc = pc; e.alu = alu; e.rd = rd; e.op = op; e.m2r = m2r;
        e.rw = flt ? 1'b0 : rw;
        e.rdata = (mr && !flt) ? rdata : 32'h0;
        e.fault = flt;
        sb_q.push_back(e);

        drive(pc, alu, sd, rd, op, rw, m2r, mr, mw);
        enable  = 1'b1;
        retired = 1'b0;
        for (int k = 0; k <= TMO + 2; k++) begin
            dmem_ready = (k == ready_at);
            dmem_rdata = (k == ready_at) ? rdata : 32'hBAD0_BAD0;
            #2;
            check("stall_out", {31'd0, stall_out}, {31'd0, (k < end_k)});
            check("dmem_req", {31'd0, dmem_req}, {31'd0, (mem && al)});
            if (k == 0 && mem) begin
                check("dmem_we", {31'd0, dmem_we}, {31'd0, mw});
                check("dmem_addr", dmem_addr, alu);
                check("dmem_wdata", dmem_wdata, sd);
            end
            if (stall_out === 1'b0) begin
                tick();
                check_retire();
                retired = 1'b1;
                break;
            end
            tick();
            check("bubble_pc", pc_out, 32'h0);
            check("bubble_rw", {31'd0, rw_out}, 32'h0);
        end
        if (!retired) begin
            tests++;
            fails++;
            $display("FAIL retire_timeout: instruction pc=%h never left the stage", pc);
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        drive(32'h0, 32'h0, 32'h0, 4'h0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        // Reset state
        check("rst_pc", pc_out, 32'h0);
        check("rst_alu", alu_out, 32'h0);
        check("rst_rdata", rdata_out, 32'h0);
        check("rst_rw", {31'd0, rw_out}, 32'h0);
        check("rst_fault", {31'd0, mem_fault}, 32'h0);
        check("rst_req", {31'd0, dmem_req}, 32'h0);
        check("rst_stall", {31'd0, stall_out}, 32'h0);

        // ADD r1 = 100
        run_instr(32'h10, 32'd100, 32'h0, 4'd1, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, -1, 32'h0);

        // enable=0 holds MEM/WB even with a new instruction presented
        enable = 1'b0;
        drive(32'h99, 32'd999, 32'h0, 4'd7, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("hold_alu", alu_out, 32'd100);
        check("hold_rd", {28'd0, rd_out}, 32'd1);
        enable = 1'b1;

        // LDR r2, [0x40], ready after 3 stalled cycles
        run_instr(32'h14, 32'h40, 32'h0, 4'd2, 5'b10010, 1'b1, 1'b1, 1'b1, 1'b0, 3, 32'hFACE_B00C);
        // STR [0x80], ready in the same cycle
        run_instr(32'h18, 32'h80, 32'h1122_3344, 4'd3, 5'b10011, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0);
        // Misaligned LDR
        run_instr(32'h1C, 32'h41, 32'h0, 4'd4, 5'b10010, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'hDEAD_0000);
        // LDR that never completes: timeout abort
        run_instr(32'h20, 32'h44, 32'h0, 4'd5, 5'b10010, 1'b1, 1'b1, 1'b1, 1'b0, -1, 32'h0);
        // CMP, no writeback
        run_instr(32'h24, 32'h7, 32'h0, 4'd0, 5'b01010, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0);
        // Ready coincides with timeout expiry: completion wins
        run_instr(32'h28, 32'h48, 32'h0, 4'd6, 5'b10010, 1'b1, 1'b1, 1'b1, 1'b0, TMO, 32'h0BAD_F00D);

        // Reset in the second WAIT cycle abandons the access
        drive(32'h2C, 32'h4C, 32'h0, 4'd8, 5'b10010, 1'b1, 1'b1, 1'b1, 1'b0);
        dmem_ready = 1'b0;
        tick();
        tick();
        check("wait_stall", {31'd0, stall_out}, 32'd1);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        check("rst_wait_req", {31'd0, dmem_req}, 32'h0);
        check("rst_wait_stall", {31'd0, stall_out}, 32'h0);
        check("rst_wait_pc", pc_out, 32'h0);
        check("rst_wait_rw", {31'd0, rw_out}, 32'h0);
        check("rst_wait_fault", {31'd0, mem_fault}, 32'h0);

        // enable=0 during WAIT: ready is ignored until enable returns
        enable = 1'b1;
        begin
            exp_t e;
            e.pc = 32'h30; e.alu = 32'h50; e.rdata = 32'h1234_5678; e.rd = 4'd9;
            e.op = 5'b10010; e.rw = 1'b1; e.m2r = 1'b1; e.fault = 1'b0;
            sb_q.push_back(e);
        end
        drive(32'h30, 32'h50, 32'h0, 4'd9, 5'b10010, 1'b1, 1'b1, 1'b1, 1'b0);
        dmem_ready = 1'b0;
        tick();
        enable     = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("frozen_req", {31'd0, dmem_req}, 32'd1);
            check("frozen_stall", {31'd0, stall_out}, 32'd1);
            tick();
            check("frozen_rw", {31'd0, rw_out}, 32'h0);
            check("frozen_rdata", rdata_out, 32'h0);
        end
        enable = 1'b1;
        #1;
        check("resume_stall", {31'd0, stall_out}, 32'h0);
        tick();
        check_retire();
        dmem_ready = 1'b0;

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
